sysid_verifier: RTL and testbench
=================================

Name: sysid_verifier

Overview:
Boot-time sequencer that drives the 1-bit-address, zero-wait-state system-ID control slave over an Avalon-MM read-only master port. On a start pulse it reads word 0 (system ID), then word 1 (build timestamp), and compares each against build-time expected values. It reports pass/fail flags and captured words to boot firmware / reset-release logic, with a per-read timeout and bounded retry so a hung interconnect cannot stall boot.

Parameters:
EXPECTED_ID, 32'h0000_0000, value that word 0 must match
EXPECTED_TS, 32'h0000_0000, value that word 1 must match
TIMEOUT_CYCLES, 16, max cycles a read may be held under waitrequest (>=1)
MAX_RETRIES, 3, extra attempts per word after a timeout (0..15)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin a check; ignored while busy=1
avm_address  out  1  0 = ID word, 1 = timestamp word
avm_read  out  1  read strobe, held until accepted
avm_readdata  in  32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0
avm_waitrequest  in  1  slave stall
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of sequence (pass, fail or timeout)
id_ok  out  1  captured ID equals EXPECTED_ID
ts_ok  out  1  captured timestamp equals EXPECTED_TS
timeout_err  out  1  retries exhausted on either read
id_value  out  32  last captured word 0
ts_value  out  32  last captured word 1

Behaviour:
- Reset (async assert, release sync to clock): state IDLE; all outputs 0, including id_value/ts_value.
- States: IDLE, RD_ID, RD_TS, FINISH.
- IDLE: start=1 -> RD_ID next cycle; clear id_ok, ts_ok, timeout_err; retry count=0, wait count=0; busy=1 from that cycle.
- RD_ID: avm_read=1, avm_address=0. Accept = avm_read & !avm_waitrequest: capture avm_readdata into id_value, set id_ok = (data==EXPECTED_ID), reset wait/retry counters, -> RD_TS. Zero-wait slave: RD_ID lasts exactly 1 cycle.
- RD_TS: same with avm_address=1, capture into ts_value/ts_ok, -> FINISH.
- Timeout: wait count increments each cycle the read is stalled; when it reaches TIMEOUT_CYCLES, deassert avm_read for exactly 1 cycle (retry gap), increment retry count, wait count=0, reissue same address. If a timeout occurs with retry count already MAX_RETRIES: set timeout_err=1, leave the failing word's ok flag 0 and its value register unchanged from this sequence's clear (i.e. previous value retained), -> FINISH without reading remaining word (ts_ok stays 0).
- Acceptance in the same cycle the wait count hits TIMEOUT_CYCLES: acceptance wins; no retry.
- FINISH: done=1 for one cycle, busy=0 in that cycle, -> IDLE. Flags and values hold until next start.
- start during busy or FINISH: ignored (not queued). start in IDLE cycle after FINISH: accepted.
- avm_address is 0 whenever avm_read=0.
- Nominal latency, zero-wait slave: start at cycle 0 -> read ID cycle 1, read TS cycle 2, done cycle 3.
- Reset asserted mid-sequence: immediate return to IDLE, avm_read drops asynchronously, no done pulse.
- Counters: wait count width clog2(TIMEOUT_CYCLES+1), retry count 4 bits; no wrap beyond limits.

Test Plan:
- Zero-wait slave returning EXPECTED_ID then EXPECTED_TS, start pulse at cycle 0 -> reads at cycles 1 (addr 0) and 2 (addr 1), done at 3, id_ok=ts_ok=1, timeout_err=0.
- Slave returns ID 32'h1234_5678 != EXPECTED_ID, TS matches -> id_value=32'h1234_5678, id_ok=0, ts_ok=1, done once, timeout_err=0.
- waitrequest high 5 cycles on ID read, TIMEOUT_CYCLES=16 -> avm_read held steady 6 cycles at addr 0, capture on 6th, no retry gap, done at cycle 8.
- waitrequest stuck high, TIMEOUT_CYCLES=4, MAX_RETRIES=2 -> 3 read windows of 4 cycles separated by 1-cycle avm_read=0 gaps, then done with timeout_err=1, id_ok=ts_ok=0, no addr-1 read ever issued.
- start re-pulsed at cycle 1 and cycle 2 during busy -> exactly one sequence, one done pulse; new start in IDLE after done -> second full sequence, flags cleared at its start.
- reset asserted during RD_TS stall -> avm_read, busy, all flags and values 0 same cycle; no done pulse; later start runs normally.

Source files
------------

// File: rtl/sysid_verifier_if.sv
// Read-only Avalon-MM link between the boot ID checker and the system-ID slave.
// A word transfers in a cycle with avm_read=1 and avm_waitrequest=0; avm_read/avm_address hold until then.
interface sysid_verifier_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sysid_verifier.sv
// Boot-time checker: reads system-ID word 0 then timestamp word 1, compares both
// against build-time constants, and bounds each read with a timeout plus retries.
module sysid_verifier #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  sysid_verifier_if.master        avm,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    timeout_err,
  output logic [31:0]             id_value,
  output logic [31:0]             ts_value,
  output logic [1:0]              dbg_state
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        RETRY_LAST = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        retry_q, retry_d;
  logic              gap_q, gap_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       id_value_q, id_value_d;
  logic [31:0]       ts_value_q, ts_value_d;

  logic reading;
  logic accept;
  logic expire;

  // gap_q marks the single idle cycle between a timed-out window and its reissue.
  assign reading = ((state_q == RD_ID) || (state_q == RD_TS)) && !gap_q;
  assign accept  = reading && !avm.avm_waitrequest;
  assign expire  = reading && avm.avm_waitrequest && (wait_q == WAIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      retry_q    <= '0;
      gap_q      <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    retry_d    = retry_q;
    gap_d      = gap_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RD_ID;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          wait_d    = '0;
          retry_d   = '0;
          gap_d     = 1'b0;
        end
      end

      RD_ID, RD_TS: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (accept) begin
          // Acceptance is tested before expiry so a late grant still counts.
          wait_d  = '0;
          retry_d = '0;
          if (state_q == RD_ID) begin
            id_value_d = avm.avm_readdata;
            id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
            state_d    = RD_TS;
          end else begin
            ts_value_d = avm.avm_readdata;
            ts_ok_d    = (avm.avm_readdata == EXPECTED_TS);
            state_d    = FINISH;
          end
        end else if (expire) begin
          wait_d = '0;
          if (retry_q == RETRY_LAST) begin
            timeout_d = 1'b1;
            state_d   = FINISH;
          end else begin
            retry_d = retry_q + 4'd1;
            gap_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign avm.avm_read    = reading;
  assign avm.avm_address = reading && (state_q == RD_TS);

  assign busy        = (state_q == RD_ID) || (state_q == RD_TS);
  assign done        = (state_q == FINISH);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sysid_verifier.sv
// Bench for sysid_verifier: scripted-stall slave, per-cycle expected bus trace
// built from the read/timeout/retry rules, and flag/value checks at done.
module tb_sysid_verifier;

  localparam int          T      = 4;
  localparam int          MAXR   = 2;
  localparam logic [31:0] EXP_ID = 32'hCAFE_0001;
  localparam logic [31:0] EXP_TS = 32'h2024_0611;

  logic        clock;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [1:0]  dbg_state;

  sysid_verifier_if avm_bus ();

  sysid_verifier #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (T),
    .MAX_RETRIES    (MAXR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .avm         (avm_bus.master),
    .busy        (busy),
    .done        (done),
    .id_ok       (id_ok),
    .ts_ok       (ts_ok),
    .timeout_err (timeout_err),
    .id_value    (id_value),
    .ts_value    (ts_value),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          stall_tab[2][16];
  int          abort_cycle = -1;
  logic [31:0] m_id_val = '0;
  logic [31:0] m_ts_val = '0;
  // per-cycle {busy, avm_read, avm_address, done}
  logic [3:0]  exp_q[$];

  task automatic set_stalls(input int id0, id1, id2, ts0, ts1, ts2);
    for (int i = 0; i < 16; i++) begin
      stall_tab[0][i] = 0;
      stall_tab[1][i] = 0;
    end
    stall_tab[0][0] = id0; stall_tab[0][1] = id1; stall_tab[0][2] = id2;
    stall_tab[1][0] = ts0; stall_tab[1][1] = ts1; stall_tab[1][2] = ts2;
  endtask

  task automatic run_sequence(input logic [31:0] id_w, input logic [31:0] ts_w,
                              input logic [15:0] restart_mask);
    logic        e_id_ok, e_ts_ok, e_to, got;
    logic [3:0]  obs;
    logic        prev_read, prev_addr;
    int          s, n, stall_left, a;
    int          att[2];

    // reference model: expand the stall script into the expected bus trace
    exp_q.delete();
    exp_q.push_back(4'b0000);
    e_id_ok = 1'b0; e_ts_ok = 1'b0; e_to = 1'b0;
    for (int w = 0; w < 2 && !e_to; w++) begin
      got = 1'b0;
      for (int t = 0; t <= MAXR && !got && !e_to; t++) begin
        s = stall_tab[w][t];
        if (s < T) begin
          repeat (s + 1) exp_q.push_back({1'b1, 1'b1, (w == 1), 1'b0});
          got = 1'b1;
          if (w == 0) begin m_id_val = id_w; e_id_ok = (id_w == EXP_ID); end
          else        begin m_ts_val = ts_w; e_ts_ok = (ts_w == EXP_TS); end
        end else begin
          repeat (T) exp_q.push_back({1'b1, 1'b1, (w == 1), 1'b0});
          if (t < MAXR) exp_q.push_back(4'b1000);
          else          e_to = 1'b1;
        end
      end
    end
    exp_q.push_back(4'b0001);
    n = exp_q.size();

    att[0] = 0; att[1] = 0; stall_left = 0;
    prev_read = 1'b0; prev_addr = 1'b0;

    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      obs = {busy, avm_bus.avm_read, avm_bus.avm_address, done};
      n_vec++;
      if (obs !== exp_q[k]) begin
        n_err++;
        $display("FAIL trace cycle %0d: busy/read/addr/done got %b required %b", k, obs, exp_q[k]);
      end
      if (k == 1) begin
        n_vec++;
        if ({id_ok, ts_ok, timeout_err} !== 3'b000) begin
          n_err++;
          $display("FAIL flags_cleared: got %b required 000", {id_ok, ts_ok, timeout_err});
        end
      end
      if (k == n - 1) begin
        n_vec++;
        if (id_ok !== e_id_ok) begin n_err++; $display("FAIL id_ok: got %b required %b", id_ok, e_id_ok); end
        n_vec++;
        if (ts_ok !== e_ts_ok) begin n_err++; $display("FAIL ts_ok: got %b required %b", ts_ok, e_ts_ok); end
        n_vec++;
        if (timeout_err !== e_to) begin n_err++; $display("FAIL timeout_err: got %b required %b", timeout_err, e_to); end
        n_vec++;
        if (id_value !== m_id_val) begin n_err++; $display("FAIL id_value: got %h required %h", id_value, m_id_val); end
        n_vec++;
        if (ts_value !== m_ts_val) begin n_err++; $display("FAIL ts_value: got %h required %h", ts_value, m_ts_val); end
      end

      // driver: start pulse and scripted slave response
      start = (k == 0) ? 1'b1 : ((k < 16) ? restart_mask[k] : 1'b0);
      a = int'(avm_bus.avm_address);
      if (avm_bus.avm_read && !(prev_read && prev_addr == avm_bus.avm_address)) begin
        stall_left = stall_tab[a][att[a]];
        if (att[a] < 15) att[a]++;
      end
      if (avm_bus.avm_read && stall_left == 0) begin
        avm_bus.avm_waitrequest = 1'b0;
        avm_bus.avm_readdata    = (a == 1) ? ts_w : id_w;
      end else begin
        avm_bus.avm_waitrequest = avm_bus.avm_read ? 1'b1 : 1'($urandom_range(0, 1));
        avm_bus.avm_readdata    = $urandom;
        if (avm_bus.avm_read) stall_left--;
      end
      prev_read = avm_bus.avm_read;
      prev_addr = avm_bus.avm_address;

      if (k == abort_cycle) begin
        n_vec++;
        if (id_value !== m_id_val) begin n_err++; $display("FAIL pre_reset_id_value: got %h required %h", id_value, m_id_val); end
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        m_id_val = '0;
        m_ts_val = '0;
        n_vec++;
        if ({avm_bus.avm_read, avm_bus.avm_address, busy, done} !== 4'b0000) begin
          n_err++;
          $display("FAIL reset_mid_bus: read/addr/busy/done got %b required 0000",
                   {avm_bus.avm_read, avm_bus.avm_address, busy, done});
        end
        n_vec++;
        if ({id_ok, ts_ok, timeout_err, id_value, ts_value} !== '0) begin
          n_err++;
          $display("FAIL reset_mid_regs: got ok=%b%b%b id=%h ts=%h required all zero",
                   id_ok, ts_ok, timeout_err, id_value, ts_value);
        end
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
          n_err++;
          $display("FAIL reset_mid_no_done: busy/done got %b required 00", {busy, done});
        end
        abort_cycle = -1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    avm_bus.avm_waitrequest = 1'b0;
    avm_bus.avm_readdata    = '0;
    repeat (3) @(negedge clock);
    n_vec++;
    if ({avm_bus.avm_read, avm_bus.avm_address, busy, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_bus: read/addr/busy/done got %b required 0000",
               {avm_bus.avm_read, avm_bus.avm_address, busy, done});
    end
    n_vec++;
    if ({id_ok, ts_ok, timeout_err, id_value, ts_value} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: got ok=%b%b%b id=%h ts=%h required all zero",
               id_ok, ts_ok, timeout_err, id_value, ts_value);
    end
    reset = 1'b0;
    m_id_val = '0;
    m_ts_val = '0;
  endtask

  task automatic test_nominal();
    set_stalls(0, 0, 0, 0, 0, 0);
    run_sequence(EXP_ID, EXP_TS, 16'h0);
  endtask

  task automatic test_id_mismatch();
    set_stalls(0, 0, 0, 0, 0, 0);
    run_sequence(32'h1234_5678, EXP_TS, 16'h0);
  endtask

  task automatic test_short_stall();
    set_stalls(T - 1, 0, 0, 2, 0, 0);
    run_sequence(EXP_ID, 32'h0BAD_0BAD, 16'h0);
  endtask

  task automatic test_retry();
    set_stalls(T, 1, 0, 99, 99, 0);
    run_sequence(EXP_ID, EXP_TS, 16'h0);
  endtask

  task automatic test_id_timeout();
    set_stalls(99, 99, 99, 0, 0, 0);
    run_sequence(32'h5555_AAAA, EXP_TS, 16'h0);
  endtask

  task automatic test_ts_timeout();
    set_stalls(0, 0, 0, 99, 99, 99);
    run_sequence(32'h7777_0000, EXP_TS, 16'h0);
  endtask

  task automatic test_back_to_back();
    // restarts at cycles 1, 2 and during FINISH are ignored
    set_stalls(0, 0, 0, 0, 0, 0);
    run_sequence(EXP_ID, EXP_TS, 16'b0000_0000_0000_1110);
    set_stalls(1, 0, 0, 0, 0, 0);
    run_sequence(32'hDEAD_BEEF, EXP_TS, 16'h0006);
  endtask

  task automatic test_random();
    logic [31:0] id_w, ts_w;
    for (int r = 0; r < 20; r++) begin
      set_stalls($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      id_w = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      ts_w = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      run_sequence(id_w, ts_w, 16'($urandom) & 16'hFFFE);
    end
  endtask

  task automatic test_reset_mid();
    set_stalls(0, 0, 0, 99, 99, 99);
    abort_cycle = 3;
    run_sequence(32'h0123_4567, EXP_TS, 16'h0);
    set_stalls(0, 0, 0, 0, 0, 0);
    run_sequence(EXP_ID, EXP_TS, 16'h0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_id_mismatch();
    test_short_stall();
    test_retry();
    test_id_timeout();
    test_ts_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
